dili_ntt_bfu: RTL and testbench

- Cooley-Tukey butterfly stage for the Dilithium NTT datapath.
- Sits directly downstream of the 4-cycle pipelined modular multiplier (dili_modMult) and instantiates it internally.
- Computes t = w*b mod Q, then a' = (a + t) mod Q and b' = (a - t) mod Q.
- Wraps the non-stallable multiplier pipeline in a valid/ready interface using a credit-protected output FIFO.

---
 rtl/dili_ntt_bfu.sv | 231 +++++++++++++++++++++++
 tb/tb_dili_ntt_bfu.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dili_ntt_bfu.sv
// Dilithium NTT butterfly: 4-cycle Barrett multiplier, add/sub stage and credit-protected output FIFO.
// Optional Gentleman-Sande mode (mode_i port) is enabled by defining DILI_BFU_GS_EN.

module dili_modMult #(
  parameter int Q = 8380417,
  parameter int L = 24
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [L-1:0] a_i,
  input  logic [L-1:0] b_i,
  output logic [L-1:0] p_o
);
  localparam int K   = 2 * L;
  localparam int MW  = L + 3;
  localparam int PW3 = 3 * L + 3;
  localparam longint unsigned MU_FULL = (64'd1 << K) / 64'(Q);
  localparam logic [MW-1:0] MU = MW'(MU_FULL);
  localparam logic [L:0]    Q1 = (L+1)'(Q);

  logic [L-1:0]  a_r;
  logic [L-1:0]  b_r;
  logic [K-1:0]  p_r;
  logic [MW-1:0] qhat_r;
  logic [L:0]    plo_r;
  logic [L:0]    r_s;
  logic [L-1:0]  p_out_r;

  // Barrett quotient estimate is at most one short, so r lies in [0, 2Q)
  assign r_s = plo_r - (L+1)'(qhat_r * MW'(Q));

  // Operand capture, product, quotient estimate, final correction
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      a_r     <= '0;
      b_r     <= '0;
      p_r     <= '0;
      qhat_r  <= '0;
      plo_r   <= '0;
      p_out_r <= '0;
    end else begin
      a_r     <= a_i;
      b_r     <= b_i;
      p_r     <= K'(a_r) * K'(b_r);
      qhat_r  <= MW'((PW3'(p_r) * PW3'(MU)) >> K);
      plo_r   <= p_r[L:0];
      p_out_r <= (r_s >= Q1) ? L'(r_s - Q1) : L'(r_s);
    end
  end

  assign p_o = p_out_r;
endmodule

module dili_ntt_bfu #(
  parameter int Q     = 8380417,
  parameter int L     = 24,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [22:0]                a_i,
  input  logic [22:0]                b_i,
  input  logic [22:0]                w_i,
`ifdef DILI_BFU_GS_EN
  input  logic                       mode_i,
`endif
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [L-1:0]               a_o,
  output logic [L-1:0]               b_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int PW  = $clog2(DEPTH);
  localparam int CRW = CW + 3;
  localparam logic [L-1:0]  QL   = L'(Q);
  localparam logic [L:0]    Q1   = (L+1)'(Q);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic           accept_s;
  logic           mode_s;
  logic [L-1:0]   a_ext_s;
  logic [L-1:0]   b_ext_s;
  logic [L-1:0]   w_ext_s;
  logic [L:0]     pre_sum_s;
  logic [L-1:0]   s_in_s;
  logic [L-1:0]   d_in_s;
  logic [L-1:0]   mult_b_s;
  logic [L-1:0]   carry_s;
  logic [L-1:0]   prod_s;

  logic [3:0]     dl_valid_r;
  logic [3:0]     dl_mode_r;
  logic [L-1:0]   dl_data_r [4];

  logic           s5_valid_r;
  logic           s5_mode_r;
  logic [L-1:0]   s5_data_r;
  logic [L-1:0]   s5_prod_r;
  logic [L:0]     s5_sum_s;
  logic [L-1:0]   a_new_s;
  logic [L-1:0]   b_new_s;

  logic [2*L-1:0] mem_r [DEPTH];
  logic [PW-1:0]  wr_ptr_r;
  logic [PW-1:0]  rd_ptr_r;
  logic [CW-1:0]  count_r;
  logic           push_s;
  logic           pop_s;
  logic [2:0]     inflight_s;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == LAST) ptr_next = '0;
    else           ptr_next = p + PW'(1);
  endfunction

`ifdef DILI_BFU_GS_EN
  assign mode_s = mode_i;
`else
  assign mode_s = 1'b0;
`endif

  assign a_ext_s  = L'(a_i);
  assign b_ext_s  = L'(b_i);
  assign w_ext_s  = L'(w_i);
  assign accept_s = in_valid_i & in_ready_o;

  // Input-side pre-add/sub (GS) and operand/carry selection
  always_comb begin
    pre_sum_s = {1'b0, a_ext_s} + {1'b0, b_ext_s};
    if (pre_sum_s >= Q1) s_in_s = L'(pre_sum_s - Q1);
    else                 s_in_s = L'(pre_sum_s);
    if (a_ext_s < b_ext_s) d_in_s = a_ext_s - b_ext_s + QL;
    else                   d_in_s = a_ext_s - b_ext_s;
    if (mode_s) begin
      mult_b_s = d_in_s;
      carry_s  = s_in_s;
    end else begin
      mult_b_s = b_ext_s;
      carry_s  = a_ext_s;
    end
  end

  dili_modMult #(.Q(Q), .L(L)) u_mult (
    .clk_i  (clk_i),
    .rst_ni (~rst_i),
    .a_i    (w_ext_s),
    .b_i    (mult_b_s),
    .p_o    (prod_s)
  );

  // Delay line keeps valid/mode/addend aligned with the multiplier pipeline
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dl_valid_r <= 4'b0000;
      dl_mode_r  <= 4'b0000;
      for (int i = 0; i < 4; i++) dl_data_r[i] <= '0;
    end else begin
      dl_valid_r   <= {dl_valid_r[2:0], accept_s};
      dl_mode_r    <= {dl_mode_r[2:0], mode_s};
      dl_data_r[0] <= carry_s;
      for (int i = 1; i < 4; i++) dl_data_r[i] <= dl_data_r[i-1];
    end
  end

  // Stage-5 register pairs the product with its delayed addend
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s5_valid_r <= 1'b0;
      s5_mode_r  <= 1'b0;
      s5_data_r  <= '0;
      s5_prod_r  <= '0;
    end else begin
      s5_valid_r <= dl_valid_r[3];
      s5_mode_r  <= dl_mode_r[3];
      s5_data_r  <= dl_data_r[3];
      s5_prod_r  <= prod_s;
    end
  end

  // Modular add/sub of the butterfly, or pass-through for GS
  always_comb begin
    s5_sum_s = {1'b0, s5_data_r} + {1'b0, s5_prod_r};
    if (s5_mode_r) begin
      a_new_s = s5_data_r;
      b_new_s = s5_prod_r;
    end else begin
      if (s5_sum_s >= Q1) a_new_s = L'(s5_sum_s - Q1);
      else                a_new_s = L'(s5_sum_s);
      if (s5_data_r < s5_prod_r) b_new_s = s5_data_r - s5_prod_r + QL;
      else                       b_new_s = s5_data_r - s5_prod_r;
    end
  end

  assign push_s = s5_valid_r;
  assign pop_s  = out_valid_o & out_ready_i;

  // Circular output FIFO; credit check below guarantees push never hits full
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {a_new_s, b_new_s};
        wr_ptr_r        <= ptr_next(wr_ptr_r);
      end
      if (pop_s) rd_ptr_r <= ptr_next(rd_ptr_r);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Results already promised to the FIFO: four delay stages plus stage 5
  always_comb begin
    inflight_s = {2'b00, dl_valid_r[0]} + {2'b00, dl_valid_r[1]} + {2'b00, dl_valid_r[2]}
               + {2'b00, dl_valid_r[3]} + {2'b00, s5_valid_r};
  end

  assign in_ready_o  = (CRW'(count_r) + CRW'(inflight_s)) < CRW'(DEPTH);
  assign out_valid_o = (count_r != '0);
  assign {a_o, b_o}  = mem_r[rd_ptr_r];
  assign count_o     = count_r;
endmodule

// File: tb/tb_dili_ntt_bfu.sv
// Self-checking bench for dili_ntt_bfu: arithmetic reference model, scoreboard queue and directed vectors.
module tb_dili_ntt_bfu;
  localparam int Q     = 8380417;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [22:0] a_in, b_in, w_in;
  logic        mode;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] a_out, b_out;
  logic [3:0]  count;

  int tests = 0;
  int fails = 0;
  int pops  = 0;
  logic [47:0] exp_q[$];

  always #5 clk = ~clk;

  dili_ntt_bfu #(.Q(Q), .L(24), .DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a_in),
    .b_i         (b_in),
    .w_i         (w_in),
`ifdef DILI_BFU_GS_EN
    .mode_i      (mode),
`endif
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .a_o         (a_out),
    .b_o         (b_out),
    .count_o     (count)
  );

  // Butterfly results straight from modular arithmetic
  function automatic logic [47:0] model(input logic [22:0] a, input logic [22:0] b,
                                        input logic [22:0] w, input logic m);
    longint unsigned ua, ub, uw, t, ap, bp, q;
    ua = 64'(a); ub = 64'(b); uw = 64'(w); q = 64'(Q);
    if (!m) begin
      t  = (uw * ub) % q;
      ap = (ua + t) % q;
      bp = (ua + q - t) % q;
    end else begin
      ap = (ua + ub) % q;
      t  = (ua + q - ub) % q;
      bp = (uw * t) % q;
    end
    model = {ap[23:0], bp[23:0]};
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: compare FIFO head with the oldest expected result, record accepts
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (count > 4'(DEPTH)) check("count_bound", longint'(count), longint'(DEPTH));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          check("out_a", longint'(a_out), longint'(exp_q[0][47:24]));
          check("out_b", longint'(b_out), longint'(exp_q[0][23:0]));
          if (out_ready) begin
            void'(exp_q.pop_front());
            pops++;
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a_in, b_in, w_in, mode));
    end
  end

  // One cycle of offering an input; ok reports whether it was accepted
  task automatic offer(input logic [22:0] a, input logic [22:0] b, input logic [22:0] w,
                       input logic m, output bit ok);
    in_valid = 1'b1; a_in = a; b_in = b; w_in = w; mode = m;
    @(negedge clk);
    ok = in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [22:0] a, input logic [22:0] b, input logic [22:0] w,
                      input logic m);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) offer(a, b, w, m, ok);
    in_valid = 1'b0;
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_out(output logic [23:0] ra, output logic [23:0] rb, output int lat);
    lat = -1; ra = '0; rb = '0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = n; ra = a_out; rb = b_out;
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] ra, rb;
    int lat, idx, acc, p0;
    bit ok;
    logic [22:0] va [12];
    logic [22:0] vb [12];
    logic [22:0] vw [12];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = 1'b0;
    a_in = '0; b_in = '0; w_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_count", longint'(count), 0);
    check("rst_a_o", longint'(a_out), 0);
    check("rst_b_o", longint'(b_out), 0);
    check("rst_in_ready", longint'(in_ready), 1);
    @(posedge clk); #1;

    // basic vector and latency
    send(23'd5, 23'd3, 23'd7, 1'b0);
    wait_out(ra, rb, lat);
    check("basic_latency", lat, 5);
    check("basic_a", longint'(ra), 26);
    check("basic_b", longint'(rb), 8380401);
    idle(3);

    // wrap-around cases
    send(23'd8380416, 23'd1, 23'd1, 1'b0);
    wait_out(ra, rb, lat);
    check("wrap1_latency", lat, 5);
    check("wrap1_a", longint'(ra), 0);
    check("wrap1_b", longint'(rb), 8380415);
    send(23'd0, 23'd5, 23'd0, 1'b0);
    wait_out(ra, rb, lat);
    check("wrap2_a", longint'(ra), 0);
    check("wrap2_b", longint'(rb), 0);
    send(23'd1234567, 23'd7654321, 23'd4000000, 1'b0);
    idle(10);

    // backpressure: FIFO plus pipeline credit caps accepts at DEPTH
    for (int i = 0; i < 12; i++) begin
      va[i] = 23'(i * 1000 + 1); vb[i] = 23'(i + 2); vw[i] = 23'(i * 37 + 5);
    end
    out_ready = 1'b0; idx = 0; acc = 0;
    for (int c = 0; c < 12; c++) begin
      offer(va[idx], vb[idx], vw[idx], 1'b0, ok);
      if (ok) begin idx++; acc++; end
    end
    in_valid = 1'b0;
    check("bp_accepted", acc, 8);
    idle(8);
    check("bp_count_full", longint'(count), 8);
    check("bp_in_ready", longint'(in_ready), 0);
    out_ready = 1'b1;
    for (int c = 0; c < 60 && idx < 12; c++) begin
      offer(va[idx], vb[idx], vw[idx], 1'b0, ok);
      if (ok) idx++;
    end
    in_valid = 1'b0;
    check("bp_rest_accepted", idx, 12);
    idle(20);
    check("bp_drained", exp_q.size(), 0);

    // streaming, out_ready high: must accept every cycle
    p0 = pops;
    for (int i = 0; i < 64; i++) begin
      offer(23'($urandom % Q), 23'($urandom % Q), 23'($urandom % Q), 1'b0, ok);
      if (!ok) check("stream_ready", 0, 1);
    end
    in_valid = 1'b0;
    idle(20);
    check("stream_count", pops - p0, 64);
    check("stream_drained", exp_q.size(), 0);

    // streaming with random backpressure
    p0 = pops; idx = 0;
    begin
      logic [22:0] ra_, rb_, rw_;
      ra_ = 23'($urandom % Q); rb_ = 23'($urandom % Q); rw_ = 23'($urandom % Q);
      for (int c = 0; c < 2000 && idx < 64; c++) begin
        out_ready = 1'($urandom_range(0, 1));
        offer(ra_, rb_, rw_, 1'b0, ok);
        if (ok) begin
          idx++;
          ra_ = 23'($urandom % Q); rb_ = 23'($urandom % Q); rw_ = 23'($urandom % Q);
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    idle(30);
    check("rand_accepts", idx, 64);
    check("rand_count", pops - p0, 64);
    check("rand_drained", exp_q.size(), 0);

    // reset in the middle of operation
    offer(23'd100, 23'd200, 23'd300, 1'b0, ok);
    offer(23'd400, 23'd500, 23'd600, 1'b0, ok);
    rst = 1'b1;
    offer(23'd700, 23'd800, 23'd900, 1'b0, ok);
    rst = 1'b0; in_valid = 1'b0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) acc++;
    end
    check("rst_discard", acc, 0);
    @(posedge clk); #1;
    p0 = pops;
    send(23'd1, 23'd1, 23'd1, 1'b0);
    wait_out(ra, rb, lat);
    check("post_rst_latency", lat, 5);
    check("post_rst_a", longint'(ra), 2);
    check("post_rst_b", longint'(rb), 0);
    idle(10);
    check("post_rst_sole", pops - p0, 1);

`ifdef DILI_BFU_GS_EN
    send(23'd5, 23'd3, 23'd7, 1'b1);
    wait_out(ra, rb, lat);
    check("gs_a", longint'(ra), 8);
    check("gs_b", longint'(rb), 14);
    idle(5);
    p0 = pops;
    for (int i = 0; i < 16; i++) begin
      offer(23'($urandom % Q), 23'($urandom % Q), 23'($urandom % Q), 1'(i % 2), ok);
      if (!ok) check("gs_stream_ready", 0, 1);
    end
    in_valid = 1'b0;
    idle(20);
    check("gs_mix_count", pops - p0, 16);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
